wb_burst_master: RTL

Wishbone master stage driving the SDRAM controller's Wishbone slave port (stb/cyc/ack, 26-bit address, 32-bit data, sel, cti). It accepts single or incrementing-burst read/write commands from the test/traffic side over valid/ready. It buffers write data and issues Wishbone B3 registered-feedback cycles. Read data returns on an unthrottled stream, and a no-ack watchdog reports errors.

---
 rtl/wb_burst_master_if.sv | 34 +++
 rtl/wb_burst_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the SDRAM controller
// slave port.
//   cyc/stb  : cycle and strobe (master drives both from one register)
//   we       : write enable
//   addr     : word address
//   dat_w    : master-to-slave write data
//   sel      : byte selects
//   cti      : cycle type identifier (000 classic, 010 incrementing, 111 end)
//   ack      : slave acknowledge
//   dat_r    : slave-to-master read data
interface wb_burst_master_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     dat_w;
    logic [DATA_W/8-1:0]   sel;
    logic [2:0]            cti;
    logic                  ack;
    logic [DATA_W-1:0]     dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel, cti,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel, cti,
        output ack, dat_r
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master. Takes single or incrementing-burst commands over
// valid/ready, buffers the write beats, then runs one registered-feedback
// cycle on the bus. Read beats come back on an unthrottled stream and a no-ack
// watchdog aborts a stuck cycle.
//   clk_i, rst_n_i      : clock, synchronous active-low reset
//   cmd_*               : command (we, first word address, beats-1, byte sel)
//   wdat_*              : write data beats, accepted only while filling
//   rdat_*              : read beats, 1-cycle pulses, last flags final beat
//   busy_o              : not idle
//   err_o               : 1-cycle pulse when the watchdog aborts a cycle
//   wb                  : Wishbone master port
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a command, bus idle
// S_FILL | collecting len+1 write beats into the buffer, bus idle
// S_BUS  | cyc/stb asserted, one beat per ack, watchdog running
module wb_burst_master #(
    parameter  int ADDR_W      = 26,
    parameter  int DATA_W      = 32,
    parameter  int MAX_BURST   = 8,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int LEN_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    localparam int SEL_W       = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    input  logic              wdat_valid_i,
    output logic              wdat_ready_o,
    input  logic [DATA_W-1:0] wdat_i,
    output logic              rdat_valid_o,
    output logic [DATA_W-1:0] rdat_o,
    output logic              rdat_last_o,
    output logic              busy_o,
    output logic              err_o,
    wb_burst_master_if.master wb
);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BUS} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [LEN_W-1:0]    fill_q, fill_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [DATA_W-1:0]   wbuf_q [MAX_BURST];

    logic                cmd_hs, wdat_hs;
    logic                rdat_valid_d, rdat_last_d, err_d;
    logic [DATA_W-1:0]   rdat_d;

    // Bus outputs are computed from the next state so they are registered
    // yet change on the same edge that consumes an ack.
    logic                cyc_q, cyc_d;
    logic                wb_we_q, wb_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    wsel_q, wsel_d;
    logic [2:0]          cti_q, cti_d;

    assign cmd_hs  = cmd_valid_i && cmd_ready_o;
    assign wdat_hs = wdat_valid_i && wdat_ready_o;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        base_d       = base_q;
        len_d        = len_q;
        sel_d        = sel_q;
        beat_d       = beat_q;
        fill_d       = fill_q;
        to_d         = to_q;
        rdat_valid_d = 1'b0;
        rdat_last_d  = 1'b0;
        rdat_d       = rdat_o;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    we_d    = cmd_we_i;
                    base_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    sel_d   = cmd_sel_i;
                    beat_d  = '0;
                    fill_d  = '0;
                    to_d    = '0;
                    state_d = cmd_we_i ? S_FILL : S_BUS;
                end
            end
            S_FILL: begin
                if (wdat_hs) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == len_q) begin
                        to_d    = '0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // An ack on the watchdog's final cycle still wins.
                if (wb.ack) begin
                    to_d = '0;
                    if (!we_q) begin
                        rdat_valid_d = 1'b1;
                        rdat_d       = wb.dat_r;
                        rdat_last_d  = (beat_q == len_q);
                    end
                    if (beat_q == len_q) state_d = S_IDLE;
                    else                 beat_d  = beat_q + 1'b1;
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cyc_d   = (state_d == S_BUS);
        wb_we_d = cyc_d && we_d;
        addr_d  = cyc_d ? base_d + ADDR_W'(beat_d) : '0;
        wsel_d  = cyc_d ? sel_d : '0;
        cti_d   = 3'b000;
        if (cyc_d && (len_d != '0)) cti_d = (beat_d == len_d) ? 3'b111 : 3'b010;
        dat_d = '0;
        // A one-beat write enters BUS on the edge that stores its only beat,
        // so the buffer has not caught up yet: forward the incoming word.
        if (wb_we_d) dat_d = (wdat_hs && (fill_q == beat_d)) ? wdat_i : wbuf_q[beat_d];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            sel_q        <= '0;
            beat_q       <= '0;
            fill_q       <= '0;
            to_q         <= '0;
            cmd_ready_o  <= 1'b0;
            wdat_ready_o <= 1'b0;
            rdat_valid_o <= 1'b0;
            rdat_o       <= '0;
            rdat_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            cyc_q        <= 1'b0;
            wb_we_q      <= 1'b0;
            addr_q       <= '0;
            dat_q        <= '0;
            wsel_q       <= '0;
            cti_q        <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            base_q       <= base_d;
            len_q        <= len_d;
            sel_q        <= sel_d;
            beat_q       <= beat_d;
            fill_q       <= fill_d;
            to_q         <= to_d;
            cmd_ready_o  <= (state_d == S_IDLE);
            wdat_ready_o <= (state_d == S_FILL);
            rdat_valid_o <= rdat_valid_d;
            rdat_o       <= rdat_d;
            rdat_last_o  <= rdat_last_d;
            busy_o       <= (state_d != S_IDLE);
            err_o        <= err_d;
            cyc_q        <= cyc_d;
            wb_we_q      <= wb_we_d;
            addr_q       <= addr_d;
            dat_q        <= dat_d;
            wsel_q       <= wsel_d;
            cti_q        <= cti_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wdat_hs) wbuf_q[fill_q] <= wdat_i;
    end

    assign wb.cyc   = cyc_q;
    assign wb.stb   = cyc_q;
    assign wb.we    = wb_we_q;
    assign wb.addr  = addr_q;
    assign wb.dat_w = dat_q;
    assign wb.sel   = wsel_q;
    assign wb.cti   = cti_q;
endmodule
